// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Hazard stall / flush control for a 5-stage MIPS-style pipeline.
//            Detects operand hazards (Tuse/Tnew) and multiply/divide unit
//            hazards. Optional stall counter: PIPE_STALL_CTRL_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  waddr_E,
    input  logic [4:0]  waddr_M,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_use_D,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    output logic        en_PC,
    output logic        en_D,
    output logic        flush_E,
    output logic        md_busy
`ifdef PIPE_STALL_CTRL_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W  = (MD_MAX < 2) ? 1 : $clog2(MD_MAX + 1);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_busy_q, md_busy_d;
    logic             stall_rs, stall_rt, stall_md, stall;

    // A $0 source never hazards; tuse of 3 (unused) can never be below a 2-bit tnew.
    always_comb begin
        stall_rs = (rs_D != 5'd0) &&
                   (((rs_D == waddr_E) && (tuse_rs_D < tnew_E)) ||
                    ((rs_D == waddr_M) && (tuse_rs_D < tnew_M)));
        stall_rt = (rt_D != 5'd0) &&
                   (((rt_D == waddr_E) && (tuse_rt_D < tnew_E)) ||
                    ((rt_D == waddr_M) && (tuse_rt_D < tnew_M)));
        stall_md = md_use_D && (md_busy_q || md_start_E);
        stall    = !reset && (stall_rs || stall_rt || stall_md);
    end

    assign en_PC   = !stall;
    assign en_D    = !stall;
    assign flush_E = stall;
    assign md_busy = md_busy_q;

    // A new start always reloads, so a back-to-back operation restarts the count.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_E) begin
            md_cnt_d = md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
        md_busy_d = (md_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

`ifdef PIPE_STALL_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
